riscv_wb_rf: RTL and testbench

Parametrised writeback stage and register file with a per-register pending-write scoreboard.
- Selects the writeback source (memory or execute) and writes the register file.
- Provides NRD combinational read ports, with optional same-cycle writeback bypass.
- Tracks in-flight destination registers so issue can detect RAW and WAW hazards.
- Sits between MEM/WB and decode/issue; x0 is hardwired to zero.

---
 rtl/riscv_wb_rf.sv | 105 ++++++++++
 tb/tb_riscv_wb_rf.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_rf.sv
// Writeback stage and register file with a per-register pending-write scoreboard.
// x0 is hardwired to zero; reads are combinational with optional same-cycle writeback bypass.
module riscv_wb_rf #(
    parameter int XLEN   = 32,
    parameter int REGN   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int REGA  = $clog2(REGN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_valid,
    input  logic [REGA-1:0]      wb_rd,
    input  logic [XLEN-1:0]      exdata,
    input  logic [XLEN-1:0]      memdata,
    input  logic                 memfetch,
    input  logic                 iss_valid,
    input  logic [REGA-1:0]      iss_rd,
    output logic                 iss_ready,
    input  logic [NRD*REGA-1:0]  rs_addr,
    output logic [NRD*XLEN-1:0]  rs_data,
    output logic [NRD-1:0]       rs_busy,
    output logic [REGN-1:0]      busy_vec,
    output logic                 write_on_zero
);

    logic [XLEN-1:0] regs_r [REGN];
    logic [REGN-1:0] busy_r;
    logic            woz_r;

    logic [XLEN-1:0] wb_data_s;
    logic            wb_clear_s;
    logic            iss_ready_s;
    logic            iss_fire_s;

    assign wb_data_s  = memfetch ? memdata : exdata;
    assign wb_clear_s = wb_valid && (wb_rd != {REGA{1'b0}});
    assign iss_fire_s = iss_valid && iss_ready_s && (iss_rd != {REGA{1'b0}});

    // Claim acceptance: a busy slot being retired this very cycle may be reclaimed.
    always_comb begin
        iss_ready_s = 1'b0;
        if (iss_rd == {REGA{1'b0}}) begin
            iss_ready_s = 1'b1;
        end else if (!busy_r[iss_rd]) begin
            iss_ready_s = 1'b1;
        end else if (wb_clear_s && (wb_rd == iss_rd)) begin
            iss_ready_s = 1'b1;
        end else begin
            iss_ready_s = 1'b0;
        end
    end

    // Register array, scoreboard and x0-write flag; set is applied after clear so a new claim wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REGN; r++) begin
                regs_r[r] <= {XLEN{1'b0}};
            end
            busy_r <= {REGN{1'b0}};
            woz_r  <= 1'b0;
        end else begin
            woz_r <= wb_valid && (wb_rd == {REGA{1'b0}});
            if (wb_clear_s) begin
                regs_r[wb_rd] <= wb_data_s;
                busy_r[wb_rd] <= 1'b0;
            end
            if (iss_fire_s) begin
                busy_r[iss_rd] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [REGA-1:0] addr_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;

        assign addr_s = rs_addr[g*REGA +: REGA];

        // Per-port read resolution: x0, then bypass, then array plus scoreboard.
        always_comb begin
            data_s = {XLEN{1'b0}};
            busy_s = 1'b0;
            if (addr_s == {REGA{1'b0}}) begin
                data_s = {XLEN{1'b0}};
                busy_s = 1'b0;
            end else if ((BYPASS != 0) && wb_valid && (wb_rd == addr_s)) begin
                data_s = wb_data_s;
                busy_s = 1'b0;
            end else begin
                data_s = regs_r[addr_s];
                busy_s = busy_r[addr_s];
            end
        end

        assign rs_data[g*XLEN +: XLEN] = data_s;
        assign rs_busy[g]              = busy_s;
    end

    assign iss_ready     = iss_ready_s;
    assign busy_vec      = busy_r;
    assign write_on_zero = woz_r;

endmodule

// File: tb/tb_riscv_wb_rf.sv
// Directed bench for riscv_wb_rf: bypassed 2-port, non-bypassed 2-port and bypassed 3-port instances
// share one stimulus stream; expected values are hand-computed constants.
module tb_riscv_wb_rf;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] exdata;
    logic [31:0] memdata;
    logic        memfetch;
    logic        iss_valid;
    logic [4:0]  iss_rd;

    logic [9:0]  rs_addr_a, rs_addr_b;
    logic [14:0] rs_addr_c;
    logic [63:0] rs_data_a, rs_data_b;
    logic [95:0] rs_data_c;
    logic [1:0]  rs_busy_a, rs_busy_b;
    logic [2:0]  rs_busy_c;
    logic [31:0] busy_vec_a, busy_vec_b, busy_vec_c;
    logic        iss_ready_a, iss_ready_b, iss_ready_c;
    logic        woz_a, woz_b, woz_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    riscv_wb_rf #(.XLEN(32), .REGN(32), .NRD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_rd(wb_rd), .exdata(exdata),
        .memdata(memdata), .memfetch(memfetch), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_ready(iss_ready_a), .rs_addr(rs_addr_a), .rs_data(rs_data_a), .rs_busy(rs_busy_a),
        .busy_vec(busy_vec_a), .write_on_zero(woz_a)
    );

    riscv_wb_rf #(.XLEN(32), .REGN(32), .NRD(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_rd(wb_rd), .exdata(exdata),
        .memdata(memdata), .memfetch(memfetch), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_ready(iss_ready_b), .rs_addr(rs_addr_b), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
        .busy_vec(busy_vec_b), .write_on_zero(woz_b)
    );

    riscv_wb_rf #(.XLEN(32), .REGN(32), .NRD(3), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_rd(wb_rd), .exdata(exdata),
        .memdata(memdata), .memfetch(memfetch), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .iss_ready(iss_ready_c), .rs_addr(rs_addr_c), .rs_data(rs_data_c), .rs_busy(rs_busy_c),
        .busy_vec(busy_vec_c), .write_on_zero(woz_c)
    );

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
        rs_addr_a = {p1, p0};
        rs_addr_b = {p1, p0};
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; exdata = 32'd0; memdata = 32'd0;
        memfetch = 1'b0; iss_valid = 1'b0; iss_rd = 5'd0;
        set_rd(5'd0, 5'd0);
        rs_addr_c = 15'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_busy_vec", busy_vec_a, 96'd0);
        check("rst_woz", woz_a, 96'd0);
        for (int a = 1; a < 32; a++) begin
            set_rd(5'(a), 5'(a));
            iss_rd = 5'(a);
            #1;
            check("rst_rd_data", rs_data_a, 96'd0);
            check("rst_rd_busy", rs_busy_a, 96'd0);
            check("rst_iss_ready", iss_ready_a, 96'd1);
        end

        // Claim x5, then load writeback of x5 read in the same cycle
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        check("claim5_busy_vec", busy_vec_a, 96'h20);
        set_rd(5'd5, 5'd0);
        wb_valid = 1'b1; wb_rd = 5'd5; memfetch = 1'b1; memdata = 32'hDEADBEEF; exdata = 32'h1234;
        #1;
        check("byp_data", rs_data_a[31:0], 96'hDEADBEEF);
        check("byp_busy", rs_busy_a[0], 96'd0);
        check("nobyp_data", rs_data_b[31:0], 96'd0);
        check("nobyp_busy", rs_busy_b[0], 96'd1);
        tick();
        wb_valid = 1'b0;
        #1;
        check("wb5_busy_vec", busy_vec_a, 96'd0);
        check("wb5_data_a", rs_data_a[31:0], 96'hDEADBEEF);
        check("wb5_data_b", rs_data_b[31:0], 96'hDEADBEEF);

        // Claim x7, retry while busy, then reclaim in the retiring cycle
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        check("claim7_busy_vec", busy_vec_a, 96'h80);
        check("busy7_iss_ready", iss_ready_a, 96'd0);
        tick();
        check("reject7_busy_vec", busy_vec_a, 96'h80);
        wb_valid = 1'b1; wb_rd = 5'd7; memfetch = 1'b0; exdata = 32'h77; memdata = 32'hBAD0BAD0;
        #1;
        check("retire7_iss_ready", iss_ready_a, 96'd1);
        tick();
        iss_valid = 1'b0; wb_valid = 1'b0;
        set_rd(5'd0, 5'd7);
        #1;
        check("reclaim7_busy_vec", busy_vec_a, 96'h80);
        check("reclaim7_data", rs_data_a[63:32], 96'h77);
        check("reclaim7_rs_busy", rs_busy_a[1], 96'd1);

        // Writeback to x0
        wb_valid = 1'b1; wb_rd = 5'd0; exdata = 32'hFFFFFFFF;
        iss_valid = 1'b1; iss_rd = 5'd0;
        #1;
        check("x0_iss_ready", iss_ready_a, 96'd1);
        check("x0_rd_data", rs_data_a[31:0], 96'd0);
        check("x0_rd_busy", rs_busy_a[0], 96'd0);
        tick();
        wb_valid = 1'b0; iss_valid = 1'b0;
        check("woz_pulse", woz_a, 96'd1);
        check("x0_busy_vec", busy_vec_a, 96'h80);
        tick();
        check("woz_clear", woz_a, 96'd0);
        check("x0_rd_after", rs_data_a[31:0], 96'd0);

        // Retire x7 (second write, exdata path)
        wb_valid = 1'b1; wb_rd = 5'd7; exdata = 32'h78;
        tick();
        wb_valid = 1'b0;
        #1;
        check("retire7_busy_vec", busy_vec_a, 96'd0);
        check("retire7_data", rs_data_b[63:32], 96'h78);

        // Pending claims x3, x9 plus write x4, then reset
        iss_valid = 1'b1; iss_rd = 5'd3;
        tick();
        iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd4; exdata = 32'h55;
        tick();
        wb_valid = 1'b0;
        set_rd(5'd4, 5'd9);
        #1;
        check("pre_rst_busy_vec", busy_vec_a, 96'h208);
        check("pre_rst_x4", rs_data_a[31:0], 96'h55);
        check("pre_rst_x9_busy", rs_busy_a[1], 96'd1);
        rst = 1'b1; wb_valid = 1'b1; wb_rd = 5'd0;
        tick();
        rst = 1'b0; wb_valid = 1'b0;
        set_rd(5'd4, 5'd5);
        #1;
        check("post_rst_busy_vec", busy_vec_a, 96'd0);
        check("post_rst_woz", woz_a, 96'd0);
        check("post_rst_x4", rs_data_a[31:0], 96'd0);
        check("post_rst_x5", rs_data_a[63:32], 96'd0);
        wb_valid = 1'b1; wb_rd = 5'd4; exdata = 32'h66;
        tick();
        wb_valid = 1'b0;
        #1;
        check("post_rst_wb_x4", rs_data_b[31:0], 96'h66);

        // Three aliased ports during a bypassed write
        rs_addr_c = {5'd2, 5'd2, 5'd2};
        wb_valid = 1'b1; wb_rd = 5'd2; exdata = 32'hA5A5; memfetch = 1'b0;
        #1;
        check("alias3_data", rs_data_c, {3{32'h0000A5A5}});
        check("alias3_busy", rs_busy_c, 96'd0);
        tick();
        wb_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
